fifo_ctrl: RTL
==============

# fifo_ctrl

Sequencing controller for the 6-entry × 8-bit `memory6x8` buffer.
- Turns requester push/pop strobes into memory `write`/`read` strobes and `wr_ptr`/`rd_ptr` pointers.
- Tracks occupancy and produces full/empty plus threshold-based almost-full/almost-empty flags for PCIe switch flow control.
- Latches thresholds through an init state and traps overflow/underflow in a sticky error state.

## Interface
Parameters:
- `DEPTH`, 6, number of memory entries; pointers wrap DEPTH-1 → 0.
- `PTR_W`, 6, pointer width; must match the memory `MAIN_SIZE`.
- `CNT_W`, 3, occupancy/threshold width; must hold the value DEPTH.

Ports:
- `clk`, in, 1, clock.
- `reset`, in, 1, reset; synchronous, active-low.
- `init`, in, 1, requests threshold (re)load.
- `af_thresh`, in, CNT_W, almost-full threshold, sampled in INIT.
- `ae_thresh`, in, CNT_W, almost-empty threshold, sampled in INIT.
- `push`, in, 1, write request; data is driven to the memory by the requester.
- `pop`, in, 1, read request.
- `mem_write`, out, 1, memory write strobe.
- `mem_read`, out, 1, memory read strobe.
- `wr_ptr`, out, PTR_W, memory write address.
- `rd_ptr`, out, PTR_W, memory read address.
- `count`, out, CNT_W, occupancy 0..DEPTH.
- `full`, `empty`, `almost_full`, `almost_empty`, out, 1 each, status flags.
- `error`, out, 1, sticky overflow/underflow indicator.
- `idle`, out, 1, high in the IDLE state.
- `state`, out, 3, current FSM state.

## Operation
FSM states: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
- **RESET**: entered whenever `reset` is 0. Next state is INIT.
- **INIT**: captures `af_thresh`/`ae_thresh` every cycle. Stays while `init`=1, then goes to IDLE. Pointers and count are untouched.
- **IDLE**: `count`=0.
  - `init`=1 → INIT.
  - Accepted push → ACTIVE.
  - Pop → ERROR.
- **ACTIVE**: `count`>0.
  - When `count` reaches 0 with no push → IDLE.
  - `init` is ignored in ACTIVE.
- **ERROR**: sticky until `reset`. `error`=1. `mem_write`/`mem_read` are held at 0.

Accept rules (IDLE/ACTIVE only):
- `mem_write` = push & (~full | pop).
- `mem_read` = pop & ~empty.
- Overflow: push & full & ~pop → ERROR, nothing written.
- Underflow: pop & empty → ERROR, even if push occurs the same cycle (no fall-through).
- Push+pop when full: both accepted, count unchanged. The read sees the old word and the write replaces it at the edge.
- Push+pop when neither full nor empty: both accepted, count unchanged.

Pointer and count updates:
- Accepted write advances `wr_ptr`; accepted read advances `rd_ptr`; both update at the clock edge.
- Pointers wrap: value DEPTH-1 + 1 → 0.
- `count` is +1 on write only, -1 on read only, unchanged on both.

Flags (combinational from registered count and thresholds):
- `full` = (count == DEPTH); `empty` = (count == 0).
- `almost_full` = (count >= af_thr); `almost_empty` = (count <= ae_thr).

In INIT, RESET and ERROR, push/pop are ignored. In INIT and RESET they do not raise an error.

## Timing
- Reset values:
  - `state`=RESET; `wr_ptr`=`rd_ptr`=0; `count`=0.
  - `af_thr`=DEPTH-1; `ae_thr`=1.
  - `mem_write`=`mem_read`=0; `empty`=1; `full`=0; `error`=0; `idle`=0.
  - Flags follow from count and thresholds: `almost_empty`=1, `almost_full`=0.
- `reset` asserted mid-operation: everything returns to reset values at the next edge. Stored memory contents are don't-care.
- Strobe and data timing:
  - `mem_write`/`mem_read` are combinational, in the same cycle as push/pop.
  - Read data is valid from the memory in the same cycle as `mem_read`, before `rd_ptr` advances.
  - Write data is stored at the edge ending the push cycle.
- Pointers, count, flags and state update one edge after the request.
- Thresholds take effect the cycle after they are sampled.

## Structure
- Shared package holds:
  - state encodings;
  - default threshold constants;
  - a DEPTH/PTR_W consistency localparam.
- One sub-module, `fifo_ptr_wrap`: a PTR_W-bit pointer register with enable and modulo-DEPTH wrap, instanced twice (write and read).

## Test plan
- Release reset, hold `init`=1 with `af_thresh`=4, `ae_thresh`=2 for 2 cycles, then drop it. Required: state RESET→INIT→IDLE, `empty`=1, `almost_empty`=1.
- Push 6 words 0x11..0x66. Required:
  - `count` goes 1..6; `wr_ptr` goes 1..5 then 0;
  - `almost_full` rises when `count`=4; `full` rises when `count`=6; state is ACTIVE.
- From full, push+pop for 3 cycles. Required:
  - reads return 0x11, 0x22, 0x33;
  - `count` stays 6; `full` stays 1; no error.
- Drain all entries. Required:
  - data returns in order;
  - `rd_ptr` wraps 5→0;
  - `almost_empty` rises when `count`=2;
  - IDLE is reached at `count`=0.
- Pop while empty (also with push in the same cycle). Required:
  - ERROR is entered; `error`=1; strobes stay 0; `count` stays 0;
  - only `reset` clears it.
- Push on full with no pop. Required: ERROR, no `mem_write`. Then assert `reset` mid-stream. Required: all outputs at reset values one edge later.

Source files
------------

// File: rtl/fifo_ctrl_pkg.sv
// Shared constants for the memory6x8 FIFO controller: state encodings,
// default thresholds and a pointer-width sanity check.
package fifo_ctrl_pkg;

  localparam logic [2:0] ST_RESET  = 3'd0;
  localparam logic [2:0] ST_INIT   = 3'd1;
  localparam logic [2:0] ST_IDLE   = 3'd2;
  localparam logic [2:0] ST_ACTIVE = 3'd3;
  localparam logic [2:0] ST_ERROR  = 3'd4;

  localparam int FIFO_DEPTH = 6;
  localparam int FIFO_PTR_W = 6;
  localparam int FIFO_CNT_W = 3;

  localparam int DEF_AE_THR = 1;
  localparam int DEF_AF_THR = FIFO_DEPTH - 1;

  // The pointer must be able to address every entry of the memory.
  localparam bit PTR_W_OK = (FIFO_DEPTH <= (1 << FIFO_PTR_W));

  function automatic int def_af_thr(input int depth);
    return depth - 1;
  endfunction

endpackage

// File: rtl/fifo_ctrl_if.sv
// Requester/memory handshake bundle: push/pop strobes in, memory strobes
// and addresses out.
interface fifo_ctrl_if
  import fifo_ctrl_pkg::*;
#(
  parameter int PTR_W = FIFO_PTR_W
);

  logic             push;
  logic             pop;
  logic             mem_write;
  logic             mem_read;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  modport master (
    output push, pop,
    input  mem_write, mem_read, wr_ptr, rd_ptr
  );

  modport slave (
    input  push, pop,
    output mem_write, mem_read, wr_ptr, rd_ptr
  );

endinterface

// File: rtl/fifo_ptr_wrap.sv
// Memory address register that advances on enable and wraps from
// DEPTH-1 back to 0.
module fifo_ptr_wrap
  import fifo_ctrl_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int PTR_W = FIFO_PTR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  output logic [PTR_W-1:0] ptr_o
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (en_i) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// Sequencing controller for the 6x8 buffer: accepts push/pop, drives the
// memory strobes/pointers, tracks occupancy and traps over/underflow.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int PTR_W = FIFO_PTR_W,
  parameter int CNT_W = FIFO_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init_i,
  input  logic [CNT_W-1:0] af_thresh_i,
  input  logic [CNT_W-1:0] ae_thresh_i,
  fifo_ctrl_if.slave       bus,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             almost_full_o,
  output logic             almost_empty_o,
  output logic             error_o,
  output logic             idle_o,
  output logic [2:0]       state_o
);

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_RESET = CNT_W'(def_af_thr(DEPTH));
  localparam logic [CNT_W-1:0] AE_RESET = CNT_W'(DEF_AE_THR);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] af_thr_q, af_thr_d;
  logic [CNT_W-1:0] ae_thr_q, ae_thr_d;

  logic             full, empty;
  logic             accept_en, overflow, underflow, wr_acc, rd_acc;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

  // An init request in IDLE wins over traffic, so requests that cycle are dropped.
  assign accept_en = (state_q == ST_ACTIVE) || ((state_q == ST_IDLE) && !init_i);
  assign underflow = accept_en && bus.pop && empty;
  assign overflow  = accept_en && bus.push && full && !bus.pop;
  assign wr_acc    = accept_en && bus.push && (!full || bus.pop) && !underflow;
  assign rd_acc    = accept_en && bus.pop && !empty;

  assign bus.mem_write = wr_acc;
  assign bus.mem_read  = rd_acc;

  fifo_ptr_wrap #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .en_i  (wr_acc),
    .ptr_o (wr_ptr)
  );

  fifo_ptr_wrap #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .en_i  (rd_acc),
    .ptr_o (rd_ptr)
  );

  assign bus.wr_ptr = wr_ptr;
  assign bus.rd_ptr = rd_ptr;

  always_comb begin
    count_d = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    af_thr_d = af_thr_q;
    ae_thr_d = ae_thr_q;
    if (state_q == ST_INIT) begin
      af_thr_d = af_thresh_i;
      ae_thr_d = ae_thresh_i;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: state_d = ST_INIT;
      ST_INIT:  state_d = init_i ? ST_INIT : ST_IDLE;
      ST_IDLE: begin
        if (underflow)   state_d = ST_ERROR;
        else if (init_i) state_d = ST_INIT;
        else if (wr_acc) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (overflow || underflow) state_d = ST_ERROR;
        else if (count_d == '0)    state_d = ST_IDLE;
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_RESET;
      count_q  <= '0;
      af_thr_q <= AF_RESET;
      ae_thr_q <= AE_RESET;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      af_thr_q <= af_thr_d;
      ae_thr_q <= ae_thr_d;
    end
  end

  assign count_o        = count_q;
  assign full_o         = full;
  assign empty_o        = empty;
  assign almost_full_o  = (count_q >= af_thr_q);
  assign almost_empty_o = (count_q <= ae_thr_q);
  assign error_o        = (state_q == ST_ERROR);
  assign idle_o         = (state_q == ST_IDLE);
  assign state_o        = state_q;

endmodule
